apb_cmd_initiator: RTL

Command-driven APB3 initiator that turns single read/write requests from a valid/ready command port into one APB3 transfer each, returning read data, PSLVERR and a timeout flag on a valid/ready response port. It sits beside the processor's APB initiator on the peripheral fabric (as a second master into the APB interconnect, or a debug/DMA path) so fabric logic can reach the UART, GPIO and Timer targets. It also guards against a hung target with a PREADY timeout.

---
 rtl/apb_cmd_initiator.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/apb_cmd_initiator.sv
// Command-port driven APB3 initiator: one valid/ready command becomes one APB3
// transfer, and its result comes back on a valid/ready response port.
// A PREADY watchdog aborts transfers to a hung target.
module apb_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        pclk_i,
  input  logic        preset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [7:0]  err_count_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        timeout_hit;

  assign timeout_hit = TO_EN && (tcnt_q == TO_LAST);

  always_ff @(posedge pclk_i) begin
    if (preset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // APB strobes and RSP_VALID are computed from the next state so they come out of flops.
  always_comb begin
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    err_count_d   = err_count_q;
    tcnt_d        = tcnt_q;
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_valid_d   = (state_d == RESP);
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_write_i ? cmd_wdata_i : 32'h0;
        end
      end
      SETUP: tcnt_d = 16'h0;
      ACCESS: begin
        if (pready_i) begin
          rsp_rdata_d   = pwrite_q ? 32'h0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'h1;
        end
      end
      default: ;
    endcase
    if ((state_q == ACCESS) && (state_d == RESP) && rsp_err_d && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'h1;
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      paddr_q       <= 32'h0;
      pwdata_q      <= 32'h0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      err_count_q   <= 8'h0;
      tcnt_q        <= 16'h0;
    end else begin
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_count_q   <= err_count_d;
      tcnt_q        <= tcnt_d;
    end
  end

  // The only combinational output: held low throughout reset.
  assign cmd_ready_o   = (state_q == IDLE) && !preset_i;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign err_count_o   = err_count_q;
  assign paddr_o       = paddr_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;

endmodule
